// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
// Holds the tracking-entry layout, the bubble value and select-width helpers.
package fwd_pkg;

  localparam int ENT_AW   = 5;
  localparam int ENT_NSRC = 2;

  function automatic int fwd_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int SEL_W = fwd_clog2(2 + 1);

  typedef struct packed {
    logic                               valid;
    logic                               reg_write;
    logic                               mem_read;
    logic [ENT_AW-1:0]                  rd;
    logic [ENT_NSRC-1:0][ENT_AW-1:0]    rs;
    logic [ENT_NSRC-1:0]                rs_used;
  } ent_t;

  localparam ent_t BUBBLE = '0;

  // x0 is hardwired zero: it never produces a value
  function automatic logic is_prod(input ent_t e);
    return e.valid & e.reg_write & (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// Priority comparator: one source register against tracked stages 1..DEPTH.
// Ports: rs/en in, ents = E[1..DEPTH] in, sel = youngest matching stage or 0.
module fwd_prio_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEL_W = 2
) (
  input  logic [ENT_AW-1:0] rs,
  input  logic              en,
  input  ent_t              ents [DEPTH],
  output logic [SEL_W-1:0]  sel
);

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel = '0;
    if (en) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (is_prod(ents[k]) && ents[k].rd == rs) begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding select and load-use stall generation for the core pipe.
// Ports: ID instruction fields + flush/clr_cnt in; stall_o, fwd_sel_o, stall_cnt_o out.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int REG_AW    = 5,
  parameter  int NUM_SRC   = 2,
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_LAT  = 1,
  parameter  int CNT_W     = 32,
  localparam int SEL_W     = fwd_clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic                     flush,
  input  logic                     clr_cnt,
  output logic                     stall_o,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  ent_t ent_q [FWD_DEPTH+1];
  ent_t older [FWD_DEPTH];
  ent_t id_ent;
  logic hazard;
  logic accept;

  always_comb begin
    id_ent           = BUBBLE;
    id_ent.valid     = 1'b1;
    id_ent.reg_write = id_reg_write;
    id_ent.mem_read  = id_mem_read;
    id_ent.rd        = ENT_AW'(id_rd);
    id_ent.rs_used   = ENT_NSRC'(id_rs_used);
    for (int j = 0; j < NUM_SRC; j++) begin
      id_ent.rs[j] = ENT_AW'(id_rs[j*REG_AW +: REG_AW]);
    end
  end

  // A load is only unresolved while it sits in stages 0..LOAD_LAT-1.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (id_rs_used[j] && is_prod(ent_q[k]) && ent_q[k].mem_read &&
            ent_q[k].rd == ENT_AW'(id_rs[j*REG_AW +: REG_AW])) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall_o = id_valid & ~flush & hazard;
  assign accept  = id_valid & ~flush & ~hazard;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        ent_q[k] <= BUBBLE;
      end
    end else begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        ent_q[k] <= ent_q[k-1];
      end
      ent_q[0] <= accept ? id_ent : BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_o <= '0;
    end else if (clr_cnt) begin
      stall_cnt_o <= '0;
    end else if (stall_o && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < FWD_DEPTH; k++) begin
      older[k] = ent_q[k+1];
    end
  end

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_op
    fwd_prio_match #(
      .DEPTH (FWD_DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .rs   (ent_q[0].rs[j]),
      .en   (ent_q[0].valid & ent_q[0].rs_used[j]),
      .ents (older),
      .sel  (fwd_sel_o[j*SEL_W +: SEL_W])
    );
  end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction.
REQ-003 SHALL have parameter FWD_DEPTH, default 2, number of tracked stages downstream of EX that can forward (1=MEM, 2=WB, ...).
REQ-004 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles, legal range 1..FWD_DEPTH.
REQ-005 SHALL have parameter CNT_W, default 32, stall-counter width; SEL_W = clog2(FWD_DEPTH+1).
REQ-006 SHALL have ports:
- clk  in  1  single clock, rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  valid instruction in ID.
- id_rd  in  REG_AW  ID destination register.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- id_rs  in  NUM_SRC*REG_AW  ID source registers, operand j at bits [j*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  operand j is actually read.
- flush  in  1  squash the ID instruction (branch taken).
- clr_cnt  in  1  synchronous clear of the stall counter.
- stall_o  out  1  hold PC/IF-ID and insert a bubble into EX.
- fwd_sel_o  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = forward from tracked stage k.
- stall_cnt_o  out  CNT_W  cumulative stall cycles.

Function
REQ-007 SHALL hold a tracking pipeline of entries E[0..FWD_DEPTH]: E[0]=EX, E[k]=k stages after EX; each entry holds valid, rd, reg_write, mem_read, rs[NUM_SRC], rs_used.
REQ-008 SHALL shift every cycle, with no enable: E[k] <= E[k-1] for k>=1, then E[0] <= ID fields when id_valid & ~stall_o & ~flush, else bubble (valid=0).
REQ-009 SHALL treat an entry as a producer only if valid & reg_write & rd!=0; register x0 never forwards and never stalls.
REQ-010 SHALL drive fwd_sel_o[j] combinationally from registered state: the smallest k in 1..FWD_DEPTH whose producer rd equals E[0].rs[j], given E[0].valid & E[0].rs_used[j]; otherwise 0. The youngest match wins.
REQ-011 SHALL assert stall_o when id_valid & ~flush and, for some j with id_rs_used[j], some producer E[k] with k<LOAD_LAT has mem_read and rd==id_rs[j].
REQ-012 SHALL treat a non-load producer matching an ID source as a non-hazard: it is resolved by forwarding, with no stall.
REQ-013 SHALL stall exactly LOAD_LAT consecutive cycles per load-use pair; the load advances past stage LOAD_LAT-1 and stall_o drops without external action.
REQ-014 SHALL give flush priority over stall: with flush=1, stall_o=0 and E[0] receives a bubble.
REQ-015 SHALL increment stall_cnt_o by 1 on each cycle with stall_o=1, saturating at all-ones; clr_cnt=1 zeroes it on that edge, and clear beats increment.
REQ-016 SHALL treat a matching ID source and destination (rd==rs) like any other; only older entries are compared.

Reset
REQ-017 SHALL, while arst_n=0, immediately clear all entry valid bits and stall_cnt_o to 0; fwd_sel_o is then all 0 and stall_o is 0.
REQ-018 SHALL start tracking on the first rising clk edge after arst_n deasserts; reset mid-stall aborts the stall and discards in-flight entries.

Structure
REQ-019 SHALL place the tracking-entry struct and the bubble constant in shared package fwd_pkg, alongside SEL_W and the clog2 helper.
REQ-020 SHALL instantiate one sub-module fwd_prio_match per operand: a priority comparator of one rs against E[1..FWD_DEPTH] that returns the SEL_W index.

Verification
REQ-021 SHALL cover: add x5 (ID), then sub x6,x5,x5 next cycle -> when sub reaches EX, fwd_sel_o = {1,1}, with no stall.
REQ-022 SHALL cover: add x5, nop, or x7,x5,x1 -> in EX, op0 sel=2, op1 sel=0; add x5 twice then use -> sel=1, youngest wins.
REQ-023 SHALL cover: lw x3 then add x4,x3,x2 with LOAD_LAT=1 -> stall_o=1 for exactly 1 cycle, then fwd_sel op0=2 (wait: load now at E[2] when add in EX? no, E[1]=bubble so E[2]=lw -> sel=2), and stall_cnt_o=1.
REQ-024 SHALL cover: LOAD_LAT=2, FWD_DEPTH=3, lw x3 then dependent -> 2 stall cycles, stall_cnt_o=2.
REQ-025 SHALL cover: writes to x0 and uses of x0 (including lw x0) -> fwd_sel_o=0 and stall_o=0 throughout.
REQ-026 SHALL cover: flush asserted during a load-use stall -> stall_o=0 that cycle, E[0] bubble; then clr_cnt, and arst_n pulsed mid-stall -> stall_cnt_o=0 and stall_o=0 immediately.
